// File: rtl/fp_iter_core_arbiter_if.sv
// Bundle of requester, shared-core and response signals for fp_iter_core_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface fp_iter_core_arbiter_if #(
    parameter int DATA_WIDTH = 57,
    parameter int ID_WIDTH   = 3
);
    logic                  div_valid;
    logic                  div_ready;
    logic [ID_WIDTH-1:0]   div_id;
    logic [DATA_WIDTH-1:0] div_a;
    logic [DATA_WIDTH-1:0] div_b;

    logic                  sqrt_valid;
    logic                  sqrt_ready;
    logic [ID_WIDTH-1:0]   sqrt_id;
    logic [DATA_WIDTH-1:0] sqrt_a;

    logic                  core_start;
    logic                  core_op;
    logic [DATA_WIDTH-1:0] core_a;
    logic [DATA_WIDTH-1:0] core_b;
    logic                  core_done;
    logic [DATA_WIDTH-1:0] core_result;
    logic [DATA_WIDTH-1:0] core_remainder;

    logic [1:0]            rsp_valid;
    logic [ID_WIDTH-1:0]   rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic [DATA_WIDTH-1:0] rsp_remainder;
    logic [1:0]            rsp_ack;

    logic                  flush;

    modport slave (
        input  div_valid, div_id, div_a, div_b,
        input  sqrt_valid, sqrt_id, sqrt_a,
        input  core_done, core_result, core_remainder,
        input  rsp_ack, flush,
        output div_ready, sqrt_ready,
        output core_start, core_op, core_a, core_b,
        output rsp_valid, rsp_id, rsp_result, rsp_remainder
    );

    modport master (
        output div_valid, div_id, div_a, div_b,
        output sqrt_valid, sqrt_id, sqrt_a,
        output core_done, core_result, core_remainder,
        output rsp_ack, flush,
        input  div_ready, sqrt_ready,
        input  core_start, core_op, core_a, core_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_remainder
    );
endinterface

// File: rtl/fp_iter_core_arbiter.sv
// Round-robin arbiter sharing one iterative divide/sqrt core between two requesters.
// Handshake: a requester's op transfers on a cycle where its valid and ready are both high.
module fp_iter_core_arbiter #(
    parameter int DATA_WIDTH = 57,
    parameter int ID_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_iter_core_arbiter_if.slave bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_sqrt;
    logic                  owner_op;
    logic [ID_WIDTH-1:0]   owner_id;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] remainder_q;

    logic                  owner_ack;
    logic                  window;
    logic                  grant_div;
    logic                  grant_sqrt;
    logic                  grant;
    logic                  capture;

    // rst is folded into the window so ready/core_start drop the instant reset asserts.
    always_comb begin
        owner_ack  = (state == HOLD) && bus.rsp_ack[owner_op];
        window     = rst && !bus.flush && ((state == IDLE) || owner_ack);
        grant_div  = window && bus.div_valid  && (!bus.sqrt_valid || last_sqrt);
        grant_sqrt = window && bus.sqrt_valid && (!bus.div_valid  || !last_sqrt);
        grant      = grant_div || grant_sqrt;
        capture    = (state == RUN) && bus.core_done && !bus.flush;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) state_next = RUN;
            end
            RUN: begin
                if (bus.flush)          state_next = bus.core_done ? IDLE : DRAIN;
                else if (bus.core_done) state_next = HOLD;
            end
            HOLD: begin
                if (bus.flush)      state_next = IDLE;
                else if (owner_ack) state_next = grant ? RUN : IDLE;
            end
            DRAIN: begin
                if (bus.core_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_sqrt <= 1'b1;
        end else begin
            state <= state_next;
            if (grant) last_sqrt <= grant_sqrt;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            owner_op <= grant_sqrt;
            owner_id <= grant_sqrt ? bus.sqrt_id : bus.div_id;
        end
        if (capture) begin
            result_q    <= bus.core_result;
            remainder_q <= bus.core_remainder;
        end
    end

    assign bus.div_ready     = grant_div;
    assign bus.sqrt_ready    = grant_sqrt;
    assign bus.core_start    = grant;
    assign bus.core_op       = grant_sqrt;
    assign bus.core_a        = grant_sqrt ? bus.sqrt_a : bus.div_a;
    assign bus.core_b        = grant_sqrt ? '0 : bus.div_b;

    assign bus.rsp_valid     = (state == HOLD) ? (owner_op ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_id        = owner_id;
    assign bus.rsp_result    = result_q;
    assign bus.rsp_remainder = remainder_q;

    assign dbg_state         = state;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(bus.div_ready && bus.sqrt_ready));
endmodule

// File: doc/fp_iter_core_arbiter.md
FP_ITER_CORE_ARBITER -- requirements
Module: fp_iter_core_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 57, width of the shared iterative core's operands, result and remainder (FRAC_WIDTH+5).
REQ-002 Parameter ID_WIDTH, default 3, width of the instruction id carried with each operation.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-005 div_valid / sqrt_valid  in  1 each  requester 0 (divide) / requester 1 (square root) has an operation pending.
REQ-006 div_ready / sqrt_ready  out  1 each  requester's operation accepted this cycle when ready&valid.
REQ-007 div_id, sqrt_id  in  ID_WIDTH each; div_a, div_b, sqrt_a  in  DATA_WIDTH each  operands.
REQ-008 core_start  out  1; core_op  out  1 (0=div, 1=sqrt); core_a, core_b  out  DATA_WIDTH  operands to the shared core.
REQ-009 core_done  in  1; core_result, core_remainder  in  DATA_WIDTH  core completion and outputs.
REQ-010 rsp_valid  out  2  one-hot owner of the held result (bit0 div, bit1 sqrt); rsp_id  out  ID_WIDTH; rsp_result, rsp_remainder  out  DATA_WIDTH.
REQ-011 rsp_ack  in  2  per-requester acknowledge; only the bit matching rsp_valid is meaningful.
REQ-012 flush  in  1  discard in-flight and held operations.

Function
REQ-013 States SHALL be IDLE, RUN, HOLD, DRAIN; reset state IDLE.
REQ-014 Acceptance window SHALL be IDLE, or HOLD with the owner's rsp_ack high; never while flush is high.
REQ-015 In the window, grant SHALL go to the single valid requester; if both valid, to the one not granted last (round-robin pointer, reset value points so div wins first tie).
REQ-016 Only the granted requester's ready SHALL be high; ready SHALL be combinational from valid, state, rsp_ack and flush.
REQ-017 On grant, core_start SHALL be high that same cycle with core_op, core_a, core_b driven from the granted requester (core_b = 0 for sqrt); id and op SHALL be registered; state -> RUN; pointer updates.
REQ-018 core_start SHALL be exactly one cycle per accepted operation and never outside a grant.
REQ-019 RUN: on core_done, core_result and core_remainder SHALL be registered and state -> HOLD; rsp_valid asserts the cycle after core_done.
REQ-020 HOLD: rsp_valid bit of owner high, rsp_id/result/remainder stable until owner's rsp_ack; on ack with no new grant -> IDLE; ack with grant -> RUN (back-to-back, zero idle cycles).
REQ-021 rsp_ack on the non-owner bit, or in any state but HOLD, SHALL be ignored.
REQ-022 flush in RUN SHALL -> DRAIN; DRAIN waits for core_done, discards it, -> IDLE; rsp_valid stays 0 throughout.
REQ-023 flush in HOLD SHALL drop the result -> IDLE (rsp_valid 0 next cycle); flush in IDLE/DRAIN no effect beyond blocking grants.
REQ-024 flush and core_done in the same RUN cycle SHALL discard the result -> IDLE.
REQ-025 core_done outside RUN/DRAIN SHALL be ignored.
REQ-026 Minimum latency accept -> rsp_valid = core latency + 1 cycle; throughput one operation per core latency + 1.

Reset
REQ-027 rst low SHALL immediately force state IDLE, rsp_valid 0, core_start 0, ready 0, pointer to div-first; data registers need no reset.
REQ-028 Reset mid-RUN SHALL abandon the operation; a core_done arriving after release in IDLE SHALL be ignored.
REQ-029 First grant possible the first clock edge after rst deasserts.

Verification
REQ-030 Single div: div_valid, id=5, a=0x100, b=0x2; core_done 4 cycles later, result 0x80 -> rsp_valid=01, rsp_id=5, rsp_result=0x80 one cycle later, held until rsp_ack[0].
REQ-031 Tie: div and sqrt valid in IDLE after reset -> div granted first; on its ack sqrt granted same cycle (core_start, core_op=1), no idle gap.
REQ-032 Fairness: both held valid for 6 operations -> grants alternate div,sqrt,div,sqrt,div,sqrt.
REQ-033 Flush in RUN with core_done 2 cycles later -> state DRAIN, rsp_valid never asserts, div_valid re-accepted only after core_done.
REQ-034 Wrong ack: rsp_valid=10, drive rsp_ack=01 -> result held, no grant; rsp_ack=10 -> release.
REQ-035 Async reset: assert rst low mid-HOLD between edges -> rsp_valid drops without a clock edge; subsequent stray core_done ignored.
